// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer: FETCH / DECODE / execute / memory /
// writeback states driving datapath mux selects and strobes, with a
// handshake to a shared, possibly stalling, instruction/data memory.
//
// Optional build macro: BRANCH_EXT_EN
//   defined   - BRANCH decodes beq/bne/blt/bge/bltu/bgeu
//   undefined - only beq is legal; alu_lt/alu_ltu are ignored
//
// state_o encoding: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5
//   EXEC_R=6 EXEC_I=7 ALUWB=8 BRANCH=9 JAL=10 LUI=11 TRAP=12
module multicycle_controller #(
  parameter int unsigned ALU_CTRL_W   = 4,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            func3,
  input  logic                  func7_5,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [3:0]            state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam int unsigned WD_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  state_e          state;
  state_e          state_next;
  alu_op_e         alu_op;
  alu_op_e         alu_func;
  logic            wait_state;
  logic            timeout;
  logic            branch_legal;
  logic            branch_taken;
  logic [WD_W-1:0] wd_cnt;

  assign state_o    = state;
  assign alu_ctrl   = ALU_CTRL_W'(alu_op);
  assign wait_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // The timeout is judged from the registered count, so the expiring cycle
  // can suppress its own strobes without a combinational loop on mem_ready.
  assign timeout    = (WAIT_TIMEOUT != 0) && wait_state && (wd_cnt == WD_W'(WAIT_TIMEOUT));

  // ALU operation for R/I arithmetic; func7_5 selects SUB only for R-type
  always_comb begin
    alu_func = ALU_ADD;
    case (func3)
      3'b000:  alu_func = (func7_5 && (state == S_EXEC_R)) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_func = ALU_SLL;
      3'b010:  alu_func = ALU_SLT;
      3'b011:  alu_func = ALU_SLTU;
      3'b100:  alu_func = ALU_XOR;
      3'b101:  alu_func = func7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_func = ALU_OR;
      default: alu_func = ALU_AND;
    endcase
  end

`ifdef BRANCH_EXT_EN
  // Branch legality and condition for the full RV32I branch set
  always_comb begin
    branch_legal = 1'b1;
    branch_taken = 1'b0;
    case (func3)
      3'b000:  branch_taken = alu_zero;
      3'b001:  branch_taken = !alu_zero;
      3'b100:  branch_taken = alu_lt;
      3'b101:  branch_taken = !alu_lt;
      3'b110:  branch_taken = alu_ltu;
      3'b111:  branch_taken = !alu_ltu;
      default: branch_legal = 1'b0;
    endcase
  end
`else
  logic unused_cmp_flags;
  assign unused_cmp_flags = alu_lt ^ alu_ltu;

  // Branch legality and condition: beq only
  always_comb begin
    branch_legal = (func3 == 3'b000);
    branch_taken = (func3 == 3'b000) && alu_zero;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Sticky trap and bus-error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (state_next == S_TRAP) illegal <= 1'b1;
      if (timeout)              bus_err <= 1'b1;
    end
  end

  // Memory stall watchdog; the count is held at zero outside the wait
  // states, which is equivalent to clearing it on entry to them.
  always_ff @(posedge clk) begin
    if (rst || (WAIT_TIMEOUT == 0))    wd_cnt <= '0;
    else if (!wait_state || mem_ready) wd_cnt <= '0;
    else if (!timeout)                 wd_cnt <= wd_cnt + 1'b1;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (timeout)        state_next = S_TRAP;
        else if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (timeout)        state_next = S_TRAP;
        else if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: begin
        if (timeout)        state_next = S_TRAP;
        else if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R:   state_next = S_ALUWB;
      S_EXEC_I:   state_next = S_ALUWB;
      S_LUI:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = branch_legal ? S_FETCH : S_TRAP;
      S_JAL:      state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // Datapath controls decoded from the registered state
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = IMM_I;
    result_src = 2'b00;
    alu_op     = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = !timeout;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready && !timeout;
        pc_write   = mem_ready && !timeout;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = !timeout;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = !timeout;
        mem_write = !timeout;
        adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = alu_func;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = alu_func;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        pc_write  = branch_legal && branch_taken;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule
